oh_reg_arb: RTL
===============

Name: oh_reg_arb

Overview:
- N-requester round-robin arbiter feeding one shared rising-edge output register stage with valid/ready handshake.
- Packet-aware: once a requester wins, the grant is held until its beat flagged last is accepted.
- Sits in front of shared datapath resources (e.g. a shared bus or memory port) so several producers share one registered pipeline stage.
- Registered output, no combinational path from out_ready to out_data.

Parameters:
- N, 4, number of requesters (2..16).
- DW, 32, data width per requester.
- SW, $clog2(N), width of source index.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- nreset  input  1  reset, asynchronous, active-low.
- in_valid  input  N  per-requester beat valid.
- in_last  input  N  per-requester last beat of packet.
- in_data  input  N*DW  requester i data at bits [i*DW +: DW].
- in_ready  output  N  per-requester beat accepted this cycle.
- out_valid  output  1  output register holds a beat.
- out_last  output  1  registered last flag.
- out_data  output  DW  registered data.
- out_src  output  SW  index of requester that produced the beat.
- out_ready  input  1  downstream accepts the beat.

Behaviour:
- Reset (async assert, sync deassert by system):
  - out_valid=0, out_last=0, out_data=0, out_src=0.
  - Priority pointer=0, state=IDLE, in_ready=0.
- load = !out_valid | out_ready. The output register takes a new beat only when load=1.
- Arbitration:
  - In IDLE, grant goes to the first requester with in_valid=1, searching from the pointer upward with wrap-around (pointer, pointer+1, …, N-1, 0, …).
  - In LOCKED, grant is forced to the locked index. Other requesters are ignored even if valid.
- in_ready[i] = load & grant[i] & in_valid[i]. At most one bit is set (onehot0). in_ready is combinational from in_valid, state and out_valid/out_ready.
- On acceptance (any in_ready bit set):
  - out_data, out_last and out_src load on the next edge. out_valid=1. Latency is 1 cycle.
- If load=1 and no requester is granted, out_valid goes to 0 on the next edge. out_data holds its old value.
- If out_valid=1 and out_ready=0, all outputs hold and in_ready=0 (stall).
- State machine:
  - IDLE -> LOCKED: a beat is accepted with in_last=0. Lock index = winner.
  - LOCKED -> IDLE: a beat is accepted from the locked index with in_last=1.
  - IDLE -> IDLE: a single-beat packet is accepted (in_last=1).
- Pointer update: on acceptance of a beat with in_last=1, pointer = winner+1, wrapping N-1 -> 0. Pointer is unchanged otherwise.
- Full throughput: with out_ready tied 1 and continuous requests, one beat per cycle. No bubble at packet boundaries or at grant switches.
- Simultaneous events: drain and refill in the same cycle (out_valid=1, out_ready=1, new grant) is legal.
- Protocol: a requester that drops in_valid mid-packet while LOCKED stalls the arbiter (no timeout, no preemption). Requesters must hold in_valid/in_data/in_last stable until in_ready.
- Reset mid-packet: returns to IDLE with pointer 0. Any in-flight beat is discarded.
- N not a power of two: pointer wraps at N, not at 2^SW.

Decomposition:
- Shared package oh_arb_pkg:
  - state encoding (IDLE=1'b0, LOCKED=1'b1);
  - function for onehot-to-index;
  - function for rotate-left/right by SW bits.
- One sub-module oh_rr_pick: combinational round-robin picker.
  - Inputs: req[N], ptr[SW].
  - Outputs: gnt[N] (onehot0), gnt_idx[SW], any.
  - Reused by other OH arbiters.

Test Plan:
- Reset:
  - Assert nreset=0 mid-traffic.
  - Expect out_valid=0, out_data=0, in_ready=0 immediately, without waiting for a clock edge.
  - After release, requesters 0 and 2 both valid -> requester 0 granted first.
- Round-robin fairness:
  - N=4, all in_valid=1, in_last=1, out_ready=1.
  - out_src sequence 0,1,2,3,0,1… with one beat per cycle, data matching the source.
- Packet lock:
  - Req1 sends 3 beats (last on beat 3) while req0 and req2 are continuously valid.
  - out_src=1,1,1 then 2, then 0.
  - in_ready[0] and in_ready[2] stay 0 during the packet.
- Backpressure:
  - out_ready=0 for 5 cycles with out_valid=1.
  - out_data/out_src stable and all in_ready=0.
  - Releasing out_ready gives drain plus refill in the same cycle.
- Wrap and non-power-of-two:
  - N=3, only req2 then req0 valid.
  - Pointer wraps 2->0. out_src=2 then 0. out_src never reaches 3.
- Gap mid-packet:
  - Req3 drops in_valid for 4 cycles while LOCKED, and req1 is valid.
  - No beats issue; out_valid goes 0 after drain.
  - On resume, req3 completes its packet before req1 is granted.

Source files
------------

// File: rtl/oh_arb_pkg.sv
// Shared definitions for the OH arbiter family: FSM encoding and the
// index/rotate helpers used by the round-robin picker.
// Helpers operate on MAX_N-wide vectors and take the live requester count n,
// so rotation wraps at n rather than at a power of two.
package oh_arb_pkg;

    localparam int unsigned MAX_N  = 16;
    localparam int unsigned MAX_SW = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Onehot (or zero) vector to bit index; zero input yields index 0.
    function automatic logic [MAX_SW-1:0] oh_to_idx(input logic [MAX_N-1:0] oh);
        logic [MAX_SW-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (oh[i]) idx = idx | MAX_SW'(i);
        end
        return idx;
    endfunction

    // res[i] = vec[(i + sh) mod n]: bit sh lands on position 0.
    function automatic logic [MAX_N-1:0] rot_right(input logic [MAX_N-1:0] vec,
                                                   input logic [MAX_SW-1:0] sh,
                                                   input int unsigned n);
        logic [MAX_N-1:0] res;
        int unsigned      j;
        res = '0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            j = i + 32'(sh);
            if (j >= n) j = j - n;
            if (i < n) res[i] = vec[MAX_SW'(j)];
        end
        return res;
    endfunction

    // res[(i + sh) mod n] = vec[i]: inverse of rot_right.
    function automatic logic [MAX_N-1:0] rot_left(input logic [MAX_N-1:0] vec,
                                                  input logic [MAX_SW-1:0] sh,
                                                  input int unsigned n);
        logic [MAX_N-1:0] res;
        int unsigned      j;
        res = '0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            j = i + 32'(sh);
            if (j >= n) j = j - n;
            if (i < n) res[MAX_SW'(j)] = vec[i];
        end
        return res;
    endfunction

endpackage

// File: rtl/oh_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr,
// wrapping at N.
//   req     : request vector
//   ptr     : highest-priority index (must be < N)
//   gnt     : onehot0 grant
//   gnt_idx : index of the granted bit (0 when nothing granted)
//   any     : at least one request present
module oh_rr_pick
    import oh_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned SW = $clog2(N)
)(
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] gnt_idx,
    output logic          any
);

    logic [MAX_N-1:0] req_rot;
    logic [MAX_N-1:0] gnt_rot;
    logic [MAX_N-1:0] gnt_full;

    // Rotate ptr to bit 0, take lowest set bit, rotate back.
    always_comb begin
        req_rot  = rot_right(MAX_N'(req), MAX_SW'(ptr), N);
        gnt_rot  = req_rot & (~req_rot + MAX_N'(1));
        gnt_full = rot_left(gnt_rot, MAX_SW'(ptr), N);
        gnt      = N'(gnt_full);
        gnt_idx  = SW'(oh_to_idx(gnt_full));
        any      = |req;
    end

endmodule

// File: rtl/oh_reg_arb.sv
// Packet-aware round-robin arbiter feeding one registered output stage.
// A winner keeps the grant until its last beat is accepted; the output
// register refills whenever it is empty or being drained.
//   clk, nreset : clock, async active-low reset
//   in_valid    : per-requester beat valid
//   in_last     : per-requester last beat of packet
//   in_data     : requester i data at [i*DW +: DW]
//   in_ready    : per-requester beat accepted this cycle (onehot0, combinational)
//   out_valid   : output register holds a beat
//   out_last    : registered last flag
//   out_data    : registered data
//   out_src     : index of the requester that produced the beat
//   out_ready   : downstream accepts the beat
module oh_reg_arb
    import oh_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 32,
    parameter int unsigned SW = $clog2(N)
)(
    input  logic            clk,
    input  logic            nreset,
    input  logic [N-1:0]    in_valid,
    input  logic [N-1:0]    in_last,
    input  logic [N*DW-1:0] in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic            out_last,
    output logic [DW-1:0]   out_data,
    output logic [SW-1:0]   out_src,
    input  logic            out_ready
);

    arb_state_e    state_q, state_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic [SW-1:0] lock_q, lock_d;

    logic          out_valid_d;
    logic          out_last_d;
    logic [DW-1:0] out_data_d;
    logic [SW-1:0] out_src_d;

    logic [N-1:0]  pick_gnt;
    logic [SW-1:0] pick_idx;
    logic          pick_any;

    logic          load_c;
    logic [N-1:0]  grant_c;
    logic          win_valid_c;
    logic [SW-1:0] win_idx_c;
    logic          win_last_c;
    logic [DW-1:0] win_data_c;
    logic          accept_c;

    oh_rr_pick #(.N(N), .SW(SW)) u_pick (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // Grant selection and handshake. in_ready is gated by nreset so it
    // drops as soon as reset asserts, not only after the next edge.
    always_comb begin
        load_c      = !out_valid || out_ready;
        grant_c     = (state_q == ST_LOCKED) ? (N'(1) << lock_q) : pick_gnt;
        win_valid_c = (state_q == ST_LOCKED) ? in_valid[lock_q] : pick_any;
        win_idx_c   = (state_q == ST_LOCKED) ? lock_q : pick_idx;
        in_ready    = (load_c && win_valid_c && nreset) ? grant_c : '0;
        accept_c    = |in_ready;
        win_last_c  = in_last[win_idx_c];
        win_data_c  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (win_idx_c == SW'(i)) win_data_c = in_data[i*DW +: DW];
        end
    end

    // Next state, pointer and output register contents.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        lock_d      = lock_q;
        out_valid_d = out_valid;
        out_last_d  = out_last;
        out_data_d  = out_data;
        out_src_d   = out_src;
        if (accept_c) begin
            out_valid_d = 1'b1;
            out_last_d  = win_last_c;
            out_data_d  = win_data_c;
            out_src_d   = win_idx_c;
            if (win_last_c) begin
                state_d = ST_IDLE;
                ptr_d   = (win_idx_c == SW'(N-1)) ? '0 : win_idx_c + SW'(1);
            end else begin
                state_d = ST_LOCKED;
                lock_d  = win_idx_c;
            end
        end else if (load_c) begin
            // Drained with nothing to refill; data is left as is.
            out_valid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            lock_q    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            lock_q    <= lock_d;
            out_valid <= out_valid_d;
            out_last  <= out_last_d;
            out_data  <= out_data_d;
            out_src   <= out_src_d;
        end
    end

endmodule
